gearbox_rx_66: RTL and testbench

- Parametrised successor to the fixed 40:66 receive gearbox.
- Packs an IN_W-bit lsbit-first stream into 66-bit blocks using an arithmetic fill accumulator, so there is no per-ratio state table.
- Adds input-valid qualification, an autonomous header hunt with programmable grace, and programmable lock/unlock thresholds.
- Sits between the transceiver deserialiser and the 64b/66b descrambler/decoder.

---
 rtl/gearbox_pkg.sv | 18 +
 rtl/gearbox_lock_fsm.sv | 118 +++++++++++
 rtl/gearbox_rx_66.sv | 89 ++++++++
 tb/tb_gearbox_rx_66.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gearbox_pkg.sv
// Shared definitions for the 64b/66b receive gearbox and its lock state machine.
package gearbox_pkg;

    localparam int unsigned BLK_W    = 66;
    localparam logic [1:0]  HDR_DATA = 2'b01;
    localparam logic [1:0]  HDR_CTRL = 2'b10;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // 00 and 11 are never legal sync headers
    function automatic logic is_bad_hdr(input logic [1:0] hdr);
        return (hdr != HDR_DATA) && (hdr != HDR_CTRL);
    endfunction

endpackage

// File: rtl/gearbox_lock_fsm.sv
// Sync-header lock tracker: grace after slips, hunt/lock counters, window error
// evaluation and autonomous slip requests while hunting.
module gearbox_lock_fsm
    import gearbox_pkg::*;
#(
    parameter int unsigned GOOD_TO_LOCK = 64,
    parameter int unsigned WINDOW       = 64,
    parameter int unsigned BAD_LIMIT    = 16,
    parameter int unsigned SLIP_GRACE   = 4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       blk_valid,
    input  logic [1:0] hdr,
    input  logic       slip_done,
    input  logic       auto_slip,
    output logic       auto_slip_req_c,
    output logic       word_locked,
    output logic [7:0] bad_hdr_cnt
);

    localparam int unsigned GOOD_W  = $clog2(GOOD_TO_LOCK + 1);
    localparam int unsigned WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned BAD_W   = $clog2(BAD_LIMIT + 1);
    localparam int unsigned GRACE_W = (SLIP_GRACE > 0) ? $clog2(SLIP_GRACE + 1) : 1;

    lock_state_e        state, state_n;
    logic [GOOD_W-1:0]  good_cnt, good_n;
    logic [WIN_W-1:0]   win_cnt, win_n;
    logic [BAD_W-1:0]   bad_win, bad_win_n, bad_acc;
    logic [GRACE_W-1:0] grace, grace_n;
    logic [7:0]         bad_tot_n;
    logic               hdr_bad, checked;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= HUNT;
            good_cnt    <= '0;
            win_cnt     <= '0;
            bad_win     <= '0;
            grace       <= '0;
            bad_hdr_cnt <= '0;
            word_locked <= 1'b0;
        end else begin
            state       <= state_n;
            good_cnt    <= good_n;
            win_cnt     <= win_n;
            bad_win     <= bad_win_n;
            grace       <= grace_n;
            bad_hdr_cnt <= bad_tot_n;
            word_locked <= (state_n == LOCKED);
        end
    end

    // The block presented alongside a slip pulse is already post-slip and is ignored
    always_comb begin
        state_n         = state;
        good_n          = good_cnt;
        win_n           = win_cnt;
        bad_win_n       = bad_win;
        bad_acc         = bad_win;
        grace_n         = grace;
        bad_tot_n       = bad_hdr_cnt;
        auto_slip_req_c = 1'b0;
        hdr_bad         = is_bad_hdr(hdr);
        checked         = blk_valid && (grace == '0) && !slip_done;

        if (slip_done) begin
            grace_n = GRACE_W'(SLIP_GRACE);
        end else if (blk_valid && (grace != '0)) begin
            grace_n = grace - GRACE_W'(1);
        end

        case (state)
            HUNT: begin
                win_n     = '0;
                bad_win_n = '0;
                if (slip_done) begin
                    good_n = '0;
                end else if (checked) begin
                    if (hdr_bad) begin
                        good_n          = '0;
                        auto_slip_req_c = auto_slip;
                    end else if (good_cnt >= GOOD_W'(GOOD_TO_LOCK - 1)) begin
                        good_n  = '0;
                        state_n = LOCKED;
                    end else begin
                        good_n = good_cnt + GOOD_W'(1);
                    end
                end
            end
            LOCKED: begin
                good_n = '0;
                if (checked && hdr_bad) begin
                    if (bad_win < BAD_W'(BAD_LIMIT)) begin
                        bad_acc = bad_win + BAD_W'(1);
                    end
                    if (bad_hdr_cnt != 8'hFF) begin
                        bad_tot_n = bad_hdr_cnt + 8'd1;
                    end
                end
                if (blk_valid) begin
                    win_n = win_cnt + WIN_W'(1);
                    if (win_cnt == WIN_W'(WINDOW - 1)) begin
                        bad_win_n = '0;
                        if (bad_acc >= BAD_W'(BAD_LIMIT)) begin
                            state_n = HUNT;
                        end
                    end else begin
                        bad_win_n = bad_acc;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gearbox_rx_66.sv
// IN_W:66 receive gearbox: packs an lsbit-first word stream into 66-bit blocks
// with an arithmetic fill accumulator, one-bit slips and header lock tracking.
module gearbox_rx_66
    import gearbox_pkg::*;
#(
    parameter int unsigned IN_W         = 40,
    parameter int unsigned GOOD_TO_LOCK = 64,
    parameter int unsigned WINDOW       = 64,
    parameter int unsigned BAD_LIMIT    = 16,
    parameter int unsigned SLIP_GRACE   = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [IN_W-1:0]  din,
    input  logic             din_valid,
    input  logic             auto_slip,
    input  logic             slip_req,
    output logic [BLK_W-1:0] dout,
    output logic             dout_valid,
    output logic             slipping,
    output logic             word_locked,
    output logic [7:0]       bad_hdr_cnt
);

    localparam int unsigned STOR_W = IN_W + BLK_W;
    localparam int unsigned FILL_W = $clog2(IN_W + BLK_W + 1);

    logic [STOR_W-1:0] stor, tmp;
    logic [FILL_W-1:0] fill, f;
    logic              pending, slip_exec, blk_done, auto_slip_req_c;

    // New word lands above the buffered bits; a slip discards the oldest bit
    always_comb begin
        slip_exec = pending && din_valid;
        tmp       = stor | (STOR_W'(din) << fill);
        f         = fill + FILL_W'(IN_W);
        if (slip_exec) begin
            tmp = tmp >> 1;
            f   = f - FILL_W'(1);
        end
        blk_done = (f >= FILL_W'(BLK_W));
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stor       <= '0;
            fill       <= '0;
            pending    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            slipping   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            slipping   <= 1'b0;
            // Requests arriving while one is outstanding collapse into it
            pending    <= pending ? !slip_exec : (slip_req || auto_slip_req_c);
            if (din_valid) begin
                slipping <= slip_exec;
                if (blk_done) begin
                    dout       <= tmp[BLK_W-1:0];
                    dout_valid <= 1'b1;
                    stor       <= tmp >> BLK_W;
                    fill       <= f - FILL_W'(BLK_W);
                end else begin
                    stor <= tmp;
                    fill <= f;
                end
            end
        end
    end

    gearbox_lock_fsm #(
        .GOOD_TO_LOCK(GOOD_TO_LOCK),
        .WINDOW      (WINDOW),
        .BAD_LIMIT   (BAD_LIMIT),
        .SLIP_GRACE  (SLIP_GRACE)
    ) u_lock (
        .clk            (clk),
        .arst           (arst),
        .blk_valid      (dout_valid),
        .hdr            (dout[1:0]),
        .slip_done      (slipping),
        .auto_slip      (auto_slip),
        .auto_slip_req_c(auto_slip_req_c),
        .word_locked    (word_locked),
        .bad_hdr_cnt    (bad_hdr_cnt)
    );

endmodule

// File: tb/tb_gearbox_rx_66.sv
// Scoreboard bench for gearbox_rx_66: a bit-queue model predicts blocks, a monitor checks them.
module tb_gearbox_rx_66;

    localparam int unsigned IN_W       = 40;
    localparam int unsigned SLIP_GRACE = 4;

    logic            clk = 1'b0;
    logic            arst;
    logic [IN_W-1:0] din;
    logic            din_valid, auto_slip, slip_req;
    logic [65:0]     dout;
    logic            dout_valid, slipping, word_locked;
    logic [7:0]      bad_hdr_cnt;

    gearbox_rx_66 #(
        .IN_W(IN_W), .GOOD_TO_LOCK(64), .WINDOW(64), .BAD_LIMIT(16), .SLIP_GRACE(SLIP_GRACE)
    ) dut (
        .clk(clk), .arst(arst), .din(din), .din_valid(din_valid), .auto_slip(auto_slip),
        .slip_req(slip_req), .dout(dout), .dout_valid(dout_valid), .slipping(slipping),
        .word_locked(word_locked), .bad_hdr_cnt(bad_hdr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [65:0] blk;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic       txq[$];
    logic       rxq[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         blk_idx = 0;
    int         slip_cnt = 0;
    int         slip_cyc = -1;
    int         since_slip = 0;
    bit         sb_on = 1'b1;
    bit         space_chk = 1'b0;
    bit         mdl_pend = 1'b0;
    logic       lock_at[512];
    logic [7:0] bad_at[512];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [65:0] gen(input int n, input logic [1:0] hdr);
        logic [31:0] a, c;
        a = 32'(n) * 32'h9E3779B1;
        c = 32'hC0DE0000 | 32'(n);
        return {a, c, hdr};
    endfunction

    function automatic logic [1:0] good_hdr(input int n);
        return (n % 2 == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr(input int n);
        return (n % 2 == 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic push_blk(input logic [65:0] b);
        for (int i = 0; i < 66; i++) txq.push_back(b[i]);
    endtask

    // One cycle of stimulus; the model predicts any block completed by this word
    task automatic drive(input bit v, input bit sreq);
        logic [IN_W-1:0] w;
        logic [65:0]     b;
        w = '0;
        b = '0;
        if (v) begin
            for (int i = 0; i < IN_W; i++) if (txq.size() > 0) w[i] = txq.pop_front();
        end
        din = w;
        din_valid = v;
        slip_req = sreq;
        if (sb_on) begin
            if (v) for (int i = 0; i < IN_W; i++) rxq.push_back(w[i]);
            if (v && mdl_pend) begin
                void'(rxq.pop_front());
                mdl_pend = 1'b0;
            end else if (!mdl_pend && sreq) begin
                mdl_pend = 1'b1;
            end
            if (rxq.size() >= 66) begin
                for (int i = 0; i < 66; i++) b[i] = rxq.pop_front();
                exp_q.push_back('{b, cyc + 1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        slip_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rxq.delete();
        txq.delete();
        mdl_pend = 1'b0;
        blk_idx = 0;
        slip_cnt = 0;
        since_slip = 0;
        arst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!arst) begin
            if (slipping) begin
                if (space_chk && slip_cnt > 0)
                    chk("slip_spacing", 66'(since_slip >= SLIP_GRACE), 66'd1);
                slip_cnt++;
                slip_cyc = cyc;
                since_slip = 0;
            end
            if (dout_valid) begin
                if (blk_idx < 512) begin
                    lock_at[blk_idx] = word_locked;
                    bad_at[blk_idx]  = bad_hdr_cnt;
                end
                blk_idx++;
                since_slip++;
                if (sb_on) begin
                    chk("block_expected", 66'(exp_q.size() != 0), 66'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("block_data", dout, e.blk);
                        chk("block_cycle", 66'(cyc), 66'(e.cyc));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        arst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        auto_slip = 1'b0;
        slip_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_dout", dout, 66'd0);
        chk("rst_dout_valid", 66'(dout_valid), 66'd0);
        chk("rst_slipping", 66'(slipping), 66'd0);
        chk("rst_word_locked", 66'(word_locked), 66'd0);
        chk("rst_bad_hdr_cnt", 66'(bad_hdr_cnt), 66'd0);
        chk("rst_fill", 66'(dut.fill), 66'd0);

        // Aligned stream, continuous valid
        do_reset();
        for (int n = 0; n < 80; n++) push_blk(gen(n, good_hdr(n)));
        for (int k = 0; k < 132; k++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("t1_blocks", 66'(blk_idx), 66'd80);
        chk("t1_drained", 66'(exp_q.size()), 66'd0);
        chk("t1_unlocked_at_64th", 66'(lock_at[63]), 66'd0);
        chk("t1_locked_after_64th", 66'(lock_at[64]), 66'd1);
        chk("t1_word_locked", 66'(word_locked), 66'd1);

        // Same kind of stream with valid toggling 1010...
        do_reset();
        for (int n = 0; n < 20; n++) push_blk(gen(n + 100, good_hdr(n)));
        for (int k = 0; k < 66; k++) drive(k % 2 == 0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("t2_blocks", 66'(blk_idx), 66'd20);
        chk("t2_drained", 66'(exp_q.size()), 66'd0);

        // 13-bit offset, autonomous hunt
        do_reset();
        sb_on = 1'b0;
        space_chk = 1'b1;
        auto_slip = 1'b1;
        for (int i = 0; i < 13; i++) txq.push_back(1'b1);
        for (int n = 0; n < 250; n++) push_blk({64'hFFFF_FFFF_FFFF_FFFF, 2'b01});
        for (int k = 0; k < 412; k++) if (!word_locked) drive(1'b1, 1'b0);
        chk("t3_locked", 66'(word_locked), 66'd1);
        chk("t3_slips", 66'(slip_cnt), 66'd13);
        chk("t3_good_run", 66'(since_slip >= 64), 66'd1);
        auto_slip = 1'b0;
        space_chk = 1'b0;
        sb_on = 1'b1;

        // Lock, 16 bad in a window drops lock, relock, 15 bad holds, window cleared
        do_reset();
        for (int n = 0; n < 330; n++) begin
            if ((n >= 70 && n < 86) || (n >= 200 && n < 215) || n == 300)
                push_blk(gen(n + 1000, bad_hdr(n)));
            else
                push_blk(gen(n + 1000, good_hdr(n)));
        end
        for (int k = 0; k < 544; k++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("t4_blocks", 66'(blk_idx), 66'd329);
        chk("t4_lock_before", 66'(lock_at[63]), 66'd0);
        chk("t4_lock_enter", 66'(lock_at[64]), 66'd1);
        chk("t4_lock_at_close", 66'(lock_at[127]), 66'd1);
        chk("t4_drop_after_16", 66'(lock_at[128]), 66'd0);
        chk("t4_bad_cnt_16", 66'(bad_at[128]), 66'd16);
        chk("t4_relock_before", 66'(lock_at[191]), 66'd0);
        chk("t4_relock", 66'(lock_at[192]), 66'd1);
        chk("t4_hold_after_15", 66'(lock_at[256]), 66'd1);
        chk("t4_bad_cnt_31", 66'(bad_at[256]), 66'd31);
        chk("t4_bad_win_cleared", 66'(lock_at[320]), 66'd1);
        chk("t4_bad_cnt_32", 66'(bad_at[320]), 66'd32);

        // Slip requests while pending and idle collapse into one slip
        do_reset();
        for (int n = 0; n < 10; n++) push_blk(gen(n + 2000, good_hdr(n)));
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1);
            drive(1'b0, 1'b0);
        end
        chk("t5_no_slip_while_idle", 66'(slip_cnt), 66'd0);
        c0 = cyc;
        drive(1'b1, 1'b0);
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("t5_one_slip", 66'(slip_cnt), 66'd1);
        chk("t5_slip_cycle", 66'(slip_cyc), 66'(c0 + 1));
        chk("t5_drained", 66'(exp_q.size()), 66'd0);

        // Asynchronous reset mid-block with fill=26
        do_reset();
        for (int n = 0; n < 40; n++) push_blk(gen(n + 3000, good_hdr(n)));
        for (int k = 0; k < 32; k++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("t6_fill_before", 66'(dut.fill), 66'd26);
        chk("t6_blocks_before", 66'(blk_idx), 66'd19);
        #2;
        arst = 1'b1;
        #1;
        chk("t6_dout", dout, 66'd0);
        chk("t6_dout_valid", 66'(dout_valid), 66'd0);
        chk("t6_fill", 66'(dut.fill), 66'd0);
        chk("t6_word_locked", 66'(word_locked), 66'd0);
        chk("t6_bad_hdr_cnt", 66'(bad_hdr_cnt), 66'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        rxq.delete();
        txq.delete();
        mdl_pend = 1'b0;
        blk_idx = 0;
        arst = 1'b0;
        push_blk(gen(4000, 2'b01));
        push_blk(gen(4001, 2'b10));
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        chk("t6_no_block_after_1_word", 66'(blk_idx), 66'd0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("t6_block_after_2_words", 66'(blk_idx), 66'd1);
        chk("t6_drained", 66'(exp_q.size()), 66'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
